// File: rtl/traffic_gen_pe.sv
// traffic_gen_pe: per-node synthetic traffic endpoint for the mesh NoC.
// Injects numPackets packets into the router local port at a fixed period,
// addressed by an LFSR-driven random pattern or by coordinate transpose, and
// counts every packet delivered back, flagging misrouted ones.
module traffic_gen_pe #(
    parameter int          X          = 8,
    parameter int          Y          = 8,
    parameter int          x_size     = $clog2(X),
    parameter int          y_size     = $clog2(Y),
    parameter int          data_width = 32,
    parameter int          numPackets = 100,
    parameter int          rate       = 1,
    parameter string       pat        = "RANDOM",
    parameter int          xcord      = 0,
    parameter int          ycord      = 0,
    parameter logic [15:0] seed       = 16'hACE1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                enableSend,
    output logic                                r_valid_pe,
    output logic [x_size+y_size+data_width-1:0] r_data_pe,
    input  logic                                r_ready_pe,
    input  logic                                w_valid_pe,
    input  logic [x_size+y_size+data_width-1:0] w_data_pe,
    output logic                                done,
    output logic [31:0]                         receiveCount,
    output logic [15:0]                         errCount
);

    localparam int PktW = x_size + y_size + data_width;
    localparam int SeqW = data_width - x_size - y_size;
    localparam bit IsTranspose = (pat == "TRANSPOSE");

    localparam logic [x_size-1:0] OwnX  = x_size'(xcord);
    localparam logic [y_size-1:0] OwnY  = y_size'(ycord);
    localparam logic [x_size-1:0] TrX   = x_size'(ycord);
    localparam logic [y_size-1:0] TrY   = y_size'(xcord);
    localparam logic [x_size-1:0] NextX = x_size'((xcord + 1) % X);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e            state_q;
    logic              valid_q;
    logic [PktW-1:0]   data_q;
    logic              done_q;
    logic [31:0]       sent_q;
    logic [31:0]       gap_q;
    logic [15:0]       lfsr_q;
    logic [31:0]       recv_q;
    logic [15:0]       err_q;

    logic              accept;
    logic [31:0]       sent_inc;
    logic [15:0]       lfsr_adv;
    logic [PktW-1:0]   pkt_cur;
    logic [PktW-1:0]   pkt_nxt;
    logic              dest_is_own;
    logic              unused_payload;

    // Assemble {dest_y, dest_x, ycord, xcord, seq}; random destinations that
    // land on this node are redirected to the next column.
    function automatic logic [PktW-1:0] build_pkt(input logic [SeqW-1:0]          seq,
                                                  input logic [x_size+y_size-1:0] rnd);
        logic [x_size-1:0] dx;
        logic [y_size-1:0] dy;
        if (IsTranspose) begin
            dx = TrX;
            dy = TrY;
        end else begin
            dx = rnd[x_size-1:0];
            dy = rnd[x_size +: y_size];
            if (dx == OwnX && dy == OwnY) begin
                dx = NextX;
            end
        end
        return {dy, dx, OwnY, OwnX, seq};
    endfunction

    // Handshake, next-state LFSR and candidate packets for the FSM
    always_comb begin
        accept   = valid_q & r_ready_pe;
        sent_inc = sent_q + 32'd1;
        lfsr_adv = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        pkt_cur  = build_pkt(SeqW'(sent_q), lfsr_q[x_size+y_size-1:0]);
        pkt_nxt  = build_pkt(SeqW'(sent_inc), lfsr_adv[x_size+y_size-1:0]);
    end

    // Send FSM with registered valid/data/done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            sent_q  <= '0;
            gap_q   <= '0;
            lfsr_q  <= seed;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (enableSend) begin
                            state_q <= StSend;
                            valid_q <= 1'b1;
                            data_q  <= pkt_cur;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (accept) begin
                        sent_q <= sent_inc;
                        lfsr_q <= lfsr_adv;
                        if (sent_inc == 32'(numPackets)) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (rate == 1) begin
                            // Back-to-back; pause without a valid if start dropped
                            valid_q <= start;
                            data_q  <= pkt_nxt;
                        end else begin
                            state_q <= StGap;
                            valid_q <= 1'b0;
                            gap_q   <= 32'(rate - 1);
                        end
                    end else if (!valid_q && start) begin
                        valid_q <= 1'b1;
                        data_q  <= pkt_cur;
                    end
                end
                StGap: begin
                    if (gap_q > 32'd1) begin
                        gap_q <= gap_q - 32'd1;
                    end else begin
                        // Gap expired; wait here with gap 0 while start is low
                        gap_q <= '0;
                        if (start) begin
                            state_q <= StSend;
                            valid_q <= 1'b1;
                            data_q  <= pkt_cur;
                        end
                    end
                end
                StDone: begin
                    if (!start) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        sent_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        dest_is_own    = (w_data_pe[PktW-1:data_width] == {OwnY, OwnX});
        unused_payload = ^w_data_pe[data_width-1:0];
    end

    // Saturating delivery and misroute counters, independent of the send side
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            recv_q <= '0;
            err_q  <= '0;
        end else if (w_valid_pe) begin
            if (recv_q != 32'hFFFF_FFFF) begin
                recv_q <= recv_q + 32'd1;
            end
            if (!dest_is_own && err_q != 16'hFFFF) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign r_valid_pe   = valid_q;
    assign r_data_pe    = data_q;
    assign done         = done_q;
    assign receiveCount = recv_q;
    assign errCount     = err_q;

endmodule

// File: tb/tb_traffic_gen_pe.sv
// Self-checking bench for traffic_gen_pe: one RANDOM node at (0,0) with
// rate 1 and one TRANSPOSE node at (2,5) with rate 3.
module tb_traffic_gen_pe;

    localparam int PW = 38;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          a_start, a_en, a_valid, a_ready, a_wvalid, a_done;
    logic [PW-1:0] a_data, a_wdata;
    logic [31:0]   a_recv;
    logic [15:0]   a_err;

    logic          b_start, b_en, b_valid, b_ready, b_wvalid, b_done;
    logic [PW-1:0] b_data, b_wdata;
    logic [31:0]   b_recv;
    logic [15:0]   b_err;

    traffic_gen_pe #(
        .numPackets(4), .rate(1), .pat("RANDOM"), .xcord(0), .ycord(0), .seed(16'hACE1)
    ) u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .enableSend(a_en),
        .r_valid_pe(a_valid), .r_data_pe(a_data), .r_ready_pe(a_ready),
        .w_valid_pe(a_wvalid), .w_data_pe(a_wdata),
        .done(a_done), .receiveCount(a_recv), .errCount(a_err)
    );

    traffic_gen_pe #(
        .numPackets(3), .rate(3), .pat("TRANSPOSE"), .xcord(2), .ycord(5), .seed(16'hACE1)
    ) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .enableSend(b_en),
        .r_valid_pe(b_valid), .r_data_pe(b_data), .r_ready_pe(b_ready),
        .w_valid_pe(b_wvalid), .w_data_pe(b_wdata),
        .done(b_done), .receiveCount(b_recv), .errCount(b_err)
    );

    int vecs = 0;
    int errs = 0;

    // Reference state for node A
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_sent = 0;
    int          m_recv = 0;
    int          m_err  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One Fibonacci step, taps 16,14,13,11, shifting toward bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int b;
        b = (int'(l) ^ (int'(l) >> 2) ^ (int'(l) >> 3) ^ (int'(l) >> 5)) & 1;
        return 16'((int'(l) >> 1) | (b << 15));
    endfunction

    // Node A is at (0,0): payload is just seq, destination from LFSR low bits
    function automatic logic [63:0] exp_a(input int seq, input logic [15:0] l);
        int dx, dy;
        dx = int'(l) % 8;
        dy = (int'(l) / 8) % 8;
        if (dx == 0 && dy == 0) dx = 1;
        return (64'(dy) << 35) | (64'(dx) << 32) | 64'(seq);
    endfunction

    // Node B at (2,5) transposes to (5,2); payload {5,2,seq}
    function automatic logic [63:0] exp_b(input int seq);
        return (64'd2 << 35) | (64'd5 << 32) | (64'd5 << 29) | (64'd2 << 26) | 64'(seq);
    endfunction

    // Run node A to completion; mode 1 stalls the 2nd packet 5 cycles, mode 2 random ready
    task automatic run_a(input int mode);
        int            acc = 0;
        int            stall = 0;
        logic          stalled = 1'b0;
        logic [PW-1:0] held = '0;
        logic          r;
        a_ready = 1'b0;
        a_start = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (a_done) break;
            if (stalled) begin
                check("valid_held", a_valid, 1);
                check("data_stable", a_data, held);
            end
            if (a_valid) begin
                if (mode == 1) r = !(acc == 1 && stall < 5);
                else           r = 1'($urandom_range(1, 0));
                if (mode == 1 && !r) stall++;
                a_ready = r;
                if (r) begin
                    check("pkt", a_data, exp_a(m_sent, m_lfsr));
                    check("not_self", (a_data[37:32] != 6'd0), 1);
                    m_sent++;
                    m_lfsr = lfsr_step(m_lfsr);
                    acc++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = a_data;
                end
            end else begin
                a_ready = 1'($urandom_range(1, 0));
            end
        end
        check("accepts", acc, 4);
        check("run_done", a_done, 1);
        if (mode == 1) check("stall_cycles", stall, 5);
        a_start = 1'b0;
        a_ready = 1'b0;
        @(negedge clk);
        check("done_fall", a_done, 0);
        m_sent = 0;
    endtask

    initial begin
        rstn = 1'b0;
        a_start = 0; a_en = 1; a_ready = 0; a_wvalid = 0; a_wdata = '0;
        b_start = 0; b_en = 1; b_ready = 0; b_wvalid = 0; b_wdata = '0;
        #12;
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_done", a_done, 0);
        check("rst_recv", a_recv, 0);
        check("rst_err", a_err, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Back-to-back burst: four consecutive valids, done on the fifth cycle
        a_ready = 1'b1;
        a_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b2b_valid", a_valid, (k < 4));
            check("b2b_done", a_done, (k == 4));
            if (k < 4) begin
                check("b2b_pkt", a_data, exp_a(m_sent, m_lfsr));
                m_sent++;
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
        a_start = 1'b0;
        @(negedge clk);
        check("b2b_done_fall", a_done, 0);
        m_sent = 0;

        run_a(1);
        run_a(2);

        // Rate 3 on node B: valids every third cycle, done one cycle after last
        b_ready = 1'b1;
        b_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rate_valid", b_valid, (k % 3 == 0 && k < 7));
            check("rate_done", b_done, (k == 7));
            if (b_valid) check("tr_pkt", b_data, exp_b(k / 3));
        end
        b_start = 1'b0;

        // Deliveries: 10 cycles with 2 misrouted, then random traffic
        for (int i = 0; i < 40; i++) begin
            logic          v;
            logic [PW-1:0] d;
            @(negedge clk);
            check("recv_cnt", a_recv, 64'(m_recv));
            check("err_cnt", a_err, 64'(m_err));
            d = PW'({$urandom, $urandom});
            if (i < 10) begin
                v = 1'b1;
                if (i == 3 || i == 7) d[37:32] = 6'(1 + $urandom_range(62, 0));
                else                  d[37:32] = 6'd0;
            end else begin
                v = 1'($urandom_range(1, 0));
                if ($urandom_range(1, 0) == 0) d[37:32] = 6'd0;
            end
            a_wvalid = v;
            a_wdata  = d;
            if (v) begin
                m_recv++;
                if (d[37:32] != 6'd0) m_err++;
            end
            if (i == 10) begin
                check("recv_ten", a_recv, 10);
                check("err_two", a_err, 2);
            end
        end
        @(negedge clk);
        a_wvalid = 1'b0;
        @(negedge clk);
        check("recv_final", a_recv, 64'(m_recv));
        check("err_final", a_err, 64'(m_err));

        // Sending disabled: straight to done, never a valid
        a_en = 1'b0;
        a_start = 1'b1;
        a_ready = 1'b1;
        @(negedge clk);
        check("nosend_done", a_done, 1);
        check("nosend_valid", a_valid, 0);
        repeat (3) begin
            @(negedge clk);
            check("nosend_valid", a_valid, 0);
        end
        a_start = 1'b0;
        @(negedge clk);
        check("nosend_done_fall", a_done, 0);
        a_en = 1'b1;

        // Asynchronous reset mid-burst, then a fresh run from seq 0 and seed
        a_start = 1'b1;
        a_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", a_valid, 0);
        check("arst_data", a_data, 0);
        check("arst_done", a_done, 0);
        check("arst_recv", a_recv, 0);
        check("arst_err", a_err, 0);
        a_start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        m_lfsr = 16'hACE1;
        m_sent = 0;
        run_a(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/traffic_gen_pe.md
# traffic_gen_pe

Per-PE synthetic traffic endpoint for the OpenNoC mesh. It injects a fixed number of packets into its router's local port at a programmable rate, using a selectable destination pattern. It counts and checks every packet the NoC delivers to it. One instance sits on each mesh node, between the router local port and the top-level bench that collects `done` and `receiveCount`.

## Interface
- `X`, 8, mesh columns; must be a power of two.
- `Y`, 8, mesh rows; must be a power of two.
- `x_size`, $clog2(X), x-coordinate field width.
- `y_size`, $clog2(Y), y-coordinate field width.
- `data_width`, 32, payload width.
- `numPackets`, 100, packets to send per run.
- `rate`, 1, injection period in cycles; must be ≥1.
- `pat`, "RANDOM", destination pattern: "RANDOM" or "TRANSPOSE".
- `xcord`, 0, own x coordinate.
- `ycord`, 0, own y coordinate.
- `seed`, 16'hACE1, LFSR seed; must be non-zero.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level: run enable.
- `enableSend`  in  1  this PE injects traffic when 1.
- `r_valid_pe`  out  1  packet valid toward router.
- `r_data_pe`  out  x_size+y_size+data_width  packet toward router.
- `r_ready_pe`  in  1  router accepts packet.
- `w_valid_pe`  in  1  packet delivered from router; there is no backpressure.
- `w_data_pe`  in  x_size+y_size+data_width  delivered packet.
- `done`  out  1  all packets of this run accepted.
- `receiveCount`  out  32  packets delivered to this PE.
- `errCount`  out  16  delivered packets whose destination is not this PE.

## Operation
- Packet layout:
  - `[data_width-1:0]` payload.
  - `[data_width +: x_size]` destination x.
  - `[data_width+x_size +: y_size]` destination y.
- Payload layout, MSB first: `{ycord, xcord, seq}`. `seq` is the count of packets already accepted, zero-extended or truncated to `data_width-x_size-y_size` bits.
- Send FSM has four states:
  - IDLE: wait until `start & enableSend`. If `start` is high and `enableSend` is low, go straight to DONE.
  - SEND: `r_valid_pe`=1. Data stays stable until `r_ready_pe`. On accept, `sent`+1. If `sent`+1==numPackets, go to DONE; otherwise go to GAP with `gap`=rate-1. If rate==1, stay in SEND.
  - GAP: decrement `gap` each cycle. Go to SEND when it reaches 0.
  - DONE: `done`=1. Return to IDLE and clear `sent` only when `start` falls.
- If `start` falls in SEND, the pending packet still completes its handshake. The FSM then holds in GAP or SEND with `r_valid_pe`=0 until `start` rises; a valid is never withdrawn.
- Destination, RANDOM pattern:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with `seed` at reset, advanced once per accepted packet.
  - dest x = `lfsr[x_size-1:0]`; dest y = `lfsr[x_size +: y_size]`.
  - If this equals own coordinates, use dest x = (xcord+1) mod X, same y.
- Destination, TRANSPOSE pattern: dest = (ycord, xcord); X==Y is required. Diagonal nodes address themselves.
- Receive side, on each cycle with `w_valid_pe`=1:
  - `receiveCount`+1, saturating at 2^32-1.
  - If the destination field differs from (xcord, ycord), `errCount`+1, saturating at 2^16-1.
- Counters are independent of `start` and cleared only by reset.

## Timing
- Reset values: `r_valid_pe`=0, `r_data_pe`=0, `done`=0, `receiveCount`=0, `errCount`=0; FSM in IDLE; LFSR=`seed`; `sent`=0.
- Reset mid-run clears everything immediately. No partial handshake survives.
- `start` sampled high at edge t (in IDLE) gives `r_valid_pe`=1 from t+1.
- Accept at edge t (valid&ready): next `r_valid_pe` rises at t+rate. rate=1 means back-to-back, one packet per cycle.
- `done` rises the cycle after the final accept and falls the cycle after `start` is sampled low.
- `receiveCount` and `errCount` update one cycle after `w_valid_pe` is sampled. A receive and a send in the same cycle are fully independent.
- Total send latency with no stalls: `numPackets` accepts take (numPackets-1)·rate+1 cycles.

## Test plan
- Reset, then start=1, enableSend=1, numPackets=4, rate=1, ready tied 1 -> valid for exactly 4 consecutive cycles; seq 0..3; done high on the 5th cycle.
- rate=3, numPackets=3, ready=1 -> valids at cycles 1, 4, 7; done at cycle 8.
- Ready held low for 5 cycles on the 2nd packet -> `r_data_pe` stable across all 5; seq=1 accepted once; total accepts still numPackets.
- TRANSPOSE, xcord=2, ycord=5 -> every packet has dest x=5, y=2. RANDOM with xcord=ycord=0 -> no packet is addressed to (0,0); destinations match the LFSR sequence from seed 16'hACE1.
- Drive w_valid_pe for 10 cycles, 2 of them with dest≠own -> receiveCount=10, errCount=2.
- enableSend=0, start=1 -> no valid ever, done=1 next cycle. Separately, rstn pulsed low mid-burst -> all outputs 0 asynchronously; the restarted run begins at seq 0.
